// File: rtl/odyssey_input_scheduler_if.sv
// odyssey_input_scheduler_if
//
// Write port between the input scheduler and the position register file.
// The scheduler is the master: it presents a channel index and an unsigned
// position and holds them until the register file accepts them.
//
// Signals:
//   wr_valid  master -> slave  write request
//   wr_ready  slave  -> master register file accepts the write this cycle
//   wr_addr   master -> slave  channel index 0..7
//   wr_data   master -> slave  unsigned position 0..255
interface odyssey_input_scheduler_if;

    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );

endinterface

// File: rtl/odyssey_input_scheduler.sv
// odyssey_input_scheduler
//
// Once per video frame, on the rising edge of vblank, takes a snapshot of
// eight signed 8-bit analogue axes (two players, LX/LY/RX/RY each) and the
// per-channel enable mask, then walks the channels in order 0..7. Every
// enabled channel is converted to an unsigned 0..255 position (with a
// centre dead zone and optional Y-axis mirroring) and written to the
// position register file over a valid/ready port. Disabled channels are
// skipped at one cycle each.
//
// Parameters:
//   DEADZONE  axis magnitudes at or below this read as centred (128)
//   INVERT_Y  when non-zero, odd channels (the Y axes) are mirrored
//
// Ports:
//   clk         single clock for all logic
//   reset_n     asynchronous active-low reset
//   vblank      vertical blank from the video timing, synchronous to clk
//   ana_bus     eight signed axes, channel n at bits [8n+7:8n]
//   chan_en     per-channel enable mask
//   wr          write port (master side): wr_valid/wr_ready/wr_addr/wr_data
//   busy        high whenever the scheduler is not idle
//   frame_done  one-cycle pulse as a frame scan completes
//   overrun     one-cycle pulse when a vblank rise arrives while busy
module odyssey_input_scheduler #(
    parameter int DEADZONE = 4,
    parameter int INVERT_Y = 0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         vblank,
    input  logic [63:0]                  ana_bus,
    input  logic [7:0]                   chan_en,
    odyssey_input_scheduler_if.master    wr,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         overrun
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        WRITE,
        DONE
    } state_t;

    // Raw axis to unsigned position. The magnitude is taken in 9 bits so
    // that -128 yields 128 rather than wrapping. Adding 128 to a two's
    // complement byte is the same as flipping its sign bit, and 255-pos
    // is the bitwise complement.
    function automatic logic [7:0] convert_axis(input logic [7:0] raw,
                                                input logic       odd_chan);
        logic [8:0] magnitude;
        logic [7:0] pos;
        magnitude = raw[7] ? (9'd256 - {1'b0, raw}) : {1'b0, raw};
        if (int'(magnitude) <= DEADZONE) begin
            pos = 8'd128;
        end else begin
            pos = raw ^ 8'h80;
        end
        if ((INVERT_Y != 0) && odd_chan) begin
            pos = ~pos;
        end
        return pos;
    endfunction

    state_t      state;
    logic [2:0]  idx;
    logic [63:0] snap_axes;
    logic [7:0]  snap_en;
    logic        vblank_q;
    logic        armed;

    logic        vblank_rise;
    logic [7:0]  cur_axis;
    logic [7:0]  cur_pos;
    logic        last_chan;

    // The vblank register comes out of reset as 0, so a vblank that is
    // already high at release would otherwise look like a rise on the very
    // first edge. 'armed' masks detection for that first edge, letting the
    // register take the real level before any rise can be seen.
    assign vblank_rise = armed & vblank & ~vblank_q;

    assign cur_axis  = snap_axes[{idx, 3'b000} +: 8];
    assign cur_pos   = convert_axis(cur_axis, idx[0]);
    assign last_chan = (idx == 3'd7);

    // Scan sequencer. All outputs are registered and updated together with
    // the state so they line up exactly with the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            idx         <= 3'd0;
            snap_axes   <= 64'd0;
            snap_en     <= 8'd0;
            vblank_q    <= 1'b0;
            armed       <= 1'b0;
            wr.wr_valid <= 1'b0;
            wr.wr_addr  <= 3'd0;
            wr.wr_data  <= 8'd0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            vblank_q   <= vblank;
            armed      <= 1'b1;
            frame_done <= 1'b0;
            // A rise while a scan is in flight is reported but otherwise
            // dropped: the scan and its snapshot are left untouched.
            overrun    <= vblank_rise && (state != IDLE);

            case (state)
                IDLE: begin
                    if (vblank_rise) begin
                        snap_axes <= ana_bus;
                        snap_en   <= chan_en;
                        idx       <= 3'd0;
                        busy      <= 1'b1;
                        state     <= SCAN;
                    end
                end

                SCAN: begin
                    if (snap_en[idx]) begin
                        wr.wr_valid <= 1'b1;
                        wr.wr_addr  <= idx;
                        wr.wr_data  <= cur_pos;
                        state       <= WRITE;
                    end else if (last_chan) begin
                        frame_done <= 1'b1;
                        state      <= DONE;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end

                WRITE: begin
                    // wr_addr/wr_data are only loaded in SCAN, so they stay
                    // put for as long as the register file stalls us.
                    if (wr.wr_ready) begin
                        wr.wr_valid <= 1'b0;
                        if (last_chan) begin
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= SCAN;
                        end
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    wr.wr_valid <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
